// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_pkg : shared types and constants for the UART program loader   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CSUM = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_FRAME = 2'b01;
  localparam logic [1:0] ERR_CSUM  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx : 8N1 receiver with 2-flop synchronizer and mid-bit sampling       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] c_half = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] c_full = CW'(DIV - 1);

  rx_state_t       r_state;
  rx_state_t       w_next;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_valid;
  logic            r_ferr;
  logic            w_tick_half;
  logic            w_tick_full;

  always_comb begin
    w_next      = r_state;
    w_tick_half = (r_cnt == c_half);
    w_tick_full = (r_cnt == c_full);
    case (r_state)
      RX_IDLE:  if (r_prev && !r_sync2) w_next = RX_START;
      // A line that is high again at mid-start-bit was only a glitch.
      RX_START: if (w_tick_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick_full && (r_bit == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_tick_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_next;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      if ((r_state == RX_IDLE) || (w_next != r_state) || w_tick_full)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (r_state == RX_IDLE)
        r_bit <= 3'd0;

      if ((r_state == RX_DATA) && w_tick_full) begin
        r_shift <= {r_sync2, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end

      if ((r_state == RX_STOP) && w_tick_full) begin
        if (r_sync2) r_valid <= 1'b1;
        else         r_ferr  <= 1'b1;
      end
    end
  end

  assign rx_data  = r_shift;
  assign rx_valid = r_valid;
  assign rx_ferr  = r_ferr;

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_prog_loader : framed, checksummed UART loader for instruction memory  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_prog_loader #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        prog_ld,
  output logic        done,
  output logic [1:0]  err,
  output logic [15:0] words_loaded
);

  import prog_loader_pkg::*;

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CYC - 1);

  logic [7:0]    w_rx_data;
  logic          w_rx_valid;
  logic          w_rx_ferr;

  state_t        r_state;
  state_t        w_next;
  logic          r_we;
  logic [15:0]   r_addr;
  logic [15:0]   r_wdata;
  logic          r_prog_ld;
  logic          r_done;
  logic [1:0]    r_err;
  logic [15:0]   r_words;
  logic [7:0]    r_len;
  logic [7:0]    r_csum;
  logic [TW-1:0] r_tmo;

  logic          w_active;
  logic          w_tmo;
  logic          w_start;
  logic          w_good;
  logic          w_fault;
  logic [1:0]    w_fault_code;

  uart_rx #(
    .DIV (DIV)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (w_rx_data),
    .rx_valid (w_rx_valid),
    .rx_ferr  (w_rx_ferr)
  );

  assign w_active = (r_state == LEN) || (r_state == HI) ||
                    (r_state == LO)  || (r_state == CSUM);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign w_tmo    = w_active && !w_rx_valid && !w_rx_ferr && (r_tmo == c_tmo_last);

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_good       = 1'b0;
    w_fault      = 1'b0;
    w_fault_code = ERR_NONE;
    case (r_state)
      IDLE, ERR: begin
        if (w_rx_valid && (w_rx_data == HDR_BYTE)) begin
          w_next  = LEN;
          w_start = 1'b1;
        end
      end
      LEN: begin
        if (w_rx_valid) begin
          if (w_rx_data == 8'h00) begin
            w_fault      = 1'b1;
            w_fault_code = ERR_CSUM;
          end else begin
            w_next = HI;
          end
        end
      end
      HI: if (w_rx_valid) w_next = LO;
      LO: begin
        if (w_rx_valid)
          w_next = ((r_words + 16'd1) == {8'h00, r_len}) ? CSUM : HI;
      end
      CSUM: begin
        if (w_rx_valid) begin
          if (w_rx_data == r_csum) begin
            w_next = IDLE;
            w_good = 1'b1;
          end else begin
            w_fault      = 1'b1;
            w_fault_code = ERR_CSUM;
          end
        end
      end
      default: w_next = IDLE;
    endcase

    if (w_active && w_rx_ferr) begin
      w_fault      = 1'b1;
      w_fault_code = ERR_FRAME;
    end else if (w_tmo) begin
      w_fault      = 1'b1;
      w_fault_code = ERR_TMO;
    end
    if (w_fault)
      w_next = ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_prog_ld <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= ERR_NONE;
      r_words   <= 16'h0000;
      r_len     <= 8'h00;
      r_csum    <= 8'h00;
      r_tmo     <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      r_done  <= 1'b0;

      if (!w_active || w_rx_valid || w_rx_ferr)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 1'b1;

      if (r_we) begin
        r_addr  <= r_addr + 16'd1;
        r_words <= r_words + 16'd1;
      end

      if (w_start) begin
        r_prog_ld <= 1'b1;
        r_err     <= ERR_NONE;
        r_words   <= 16'h0000;
        r_addr    <= 16'h0000;
        r_csum    <= 8'h00;
      end

      if (w_fault)
        r_err <= w_fault_code;

      if (w_rx_valid) begin
        case (r_state)
          LEN: r_len <= w_rx_data;
          HI: begin
            r_wdata[15:8] <= w_rx_data;
            r_csum        <= r_csum ^ w_rx_data;
          end
          LO: begin
            r_wdata[7:0] <= w_rx_data;
            r_csum       <= r_csum ^ w_rx_data;
            r_we         <= 1'b1;
          end
          CSUM: begin
            if (w_good) begin
              r_done    <= 1'b1;
              r_prog_ld <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign prog_ld      = r_prog_ld;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader feeding the CPU's instruction memory on the DE2-115. It receives 8N1 UART bytes from the Bluetooth module on a GPIO pin and assembles them into 16-bit big-endian words. Each framed, checksummed word is written to sequential instruction-memory addresses while `prog_ld` holds the CPU in reset. It replaces the ad-hoc address counter in the top level; `hex_debugger` can display its status word.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 9600, UART bit rate; `DIV = CLK_HZ/BAUD` (5208 at defaults).
- `TIMEOUT_CYC`, 50_000_000, maximum idle cycles between bytes inside a frame.
- `clk  in  1`  system clock; all logic on rising edge.
- `rst_n  in  1`  reset, synchronous and active-low.
- `rx  in  1`  asynchronous UART line; idle high.
- `imem_we  out  1`  one-cycle write strobe.
- `imem_addr  out  16`  word address of the current write.
- `imem_wdata  out  16`  word being written.
- `prog_ld  out  1`  high while a load is in progress or has failed; drives CPU reset.
- `done  out  1`  one-cycle pulse when a frame completes with a good checksum.
- `err  out  2`  sticky error code: 00 none, 01 framing, 10 checksum, 11 timeout.
- `words_loaded  out  16`  number of words written in the current or last frame.

## Operation
- Frame format: `0xA5` header, then length byte N (1..255 words), then 2N data bytes (high byte first), then XOR checksum of the 2N data bytes.
- FSM states: IDLE → LEN → HI → LO → (HI while words remain, else CSUM) → IDLE; any state → ERR on a fault.
- IDLE: bytes other than `0xA5` are ignored.
  - On `0xA5`: set `prog_ld`=1, clear `err`, `words_loaded`, `imem_addr` and the checksum accumulator.
- LEN: N=0 is treated as a checksum error (`err`=10) and goes to ERR.
- HI: latch the byte into `imem_wdata[15:8]`.
- LO: latch the byte into `imem_wdata[7:0]`, then pulse `imem_we`. After the write, `imem_addr` and `words_loaded` increment.
- CSUM, match: pulse `done`, set `prog_ld`=0, go to IDLE.
- CSUM, mismatch: `err`=10, go to ERR.
- ERR: `prog_ld` stays 1 and `err` holds. A new `0xA5` byte restarts the load from address 0, exactly as from IDLE.
- Timeout: a counter clears on every received byte. It reaches `TIMEOUT_CYC` only in LEN/HI/LO/CSUM, then `err`=11 and the FSM goes to ERR. The counter is inactive in IDLE and ERR.
- Framing error: stop bit sampled 0. The byte is discarded.
  - In IDLE or ERR it is ignored.
  - Otherwise `err`=01 and the FSM goes to ERR.
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `prog_ld`=0, `done`=0, `err`=00, `words_loaded`=0, FSM=IDLE, receiver idle.
- Reset mid-frame: the frame is abandoned and the outputs return to their reset values. Words already written stay in memory.

## Timing
- `rx` passes through a 2-flop synchronizer (2 cycles latency).
- Receiver start detect:
  - A start is a synchronized falling edge.
  - The line is re-sampled at DIV/2; if it is high, it was a glitch and the receiver returns to idle.
- Data bits are sampled every DIV cycles after that point, LSB first, followed by the stop bit.
- `rx_valid` (internal) pulses for one cycle, on the cycle after the stop-bit sample.
- Loader response:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered and valid together on the cycle after the `rx_valid` of the LO byte.
  - `imem_addr` increments on the cycle after `imem_we`.
  - `done` asserts and `prog_ld` falls on the cycle after the `rx_valid` of the checksum byte.
- Address wrap: N ≤ 255, so `imem_addr` never wraps within a frame.
- At most one byte event per cycle. A timeout and an `rx_valid` in the same cycle resolve in favour of the byte.

## Structure
- Shared package `prog_loader_pkg`:
  - state enum (IDLE, LEN, HI, LO, CSUM, ERR);
  - `HDR_BYTE`=8'hA5;
  - error codes `ERR_NONE`, `ERR_FRAME`, `ERR_CSUM`, `ERR_TMO`.
- Sub-module `uart_rx`: synchronizer, baud counter and bit shifter. Outputs `rx_data[7:0]`, `rx_valid`, `rx_ferr`; parameter `DIV`.
- The top of the block holds the frame FSM, checksum XOR, address/word counters and timeout counter.

## Test plan
- Reset and idle line: assert `rst_n`=0 for 3 cycles while `rx`=1 → all outputs are 0 and no `imem_we` occurs for 10·DIV cycles.
- Good frame A5 02 12 34 AB CD 40 → `imem_we` at address 0 with data 0x1234, then at address 1 with data 0xABCD. `done` pulses once, `prog_ld` falls, `words_loaded`=2, `err`=00.
- Bad checksum A5 01 00 FF 00 → one write of 0x00FF at address 0, then `err`=10, `prog_ld` stays 1, no `done`. A following good frame A5 01 BE EF 51 → write of 0xBEEF at address 0, then `done`.
- Timeout: send A5 01 12, then hold `rx` idle for `TIMEOUT_CYC` (shortened to 1000 for simulation) → `err`=11, `prog_ld`=1, no write.
- Framing error: send the byte after the header with its stop bit forced to 0 → `err`=01, FSM in ERR.
- Glitch and garbage:
  - a 0.25-bit low pulse on `rx` produces no byte;
  - bytes 00 FF 5A in IDLE leave `prog_ld`=0.
- Reset mid-frame: pulse `rst_n` low after the HI byte → outputs return to reset values and the next frame loads from address 0.
